// File: rtl/fp_exc_pkg.sv
// Shared definitions for the FP exception pipe: opcodes, operand classes and a
// canonical quiet-NaN builder usable for any exponent/mantissa split.
package fp_exc_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [2:0] {
      ClsZero,
      ClsSubnormal,
      ClsNormal,
      ClsInf,
      ClsQnan,
      ClsSnan
   } fp_class_e;

   localparam int unsigned MAX_DATA_W = 128;
   localparam logic [MAX_DATA_W-1:0] ONE_W = {{(MAX_DATA_W-1){1'b0}}, 1'b1};

   // Sign 0, exponent all ones, mantissa MSB set; caller truncates to its width.
   function automatic logic [MAX_DATA_W-1:0] canon_qnan(input int unsigned exp_w,
                                                        input int unsigned man_w);
      return (((ONE_W << exp_w) - ONE_W) << man_w) | (ONE_W << (man_w - 1));
   endfunction

endpackage

// File: rtl/fp_classify.sv
// Operand classifier for the FP exception pipe.
// Define FP_EXC_DAZ_EN to fold subnormal operands into signed zero.
module fp_classify
   import fp_exc_pkg::*;
#(
   parameter int EXP_WIDTH = 8,
   parameter int MAN_WIDTH = 23,
   localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] i_num,
   output fp_class_e             o_class,
   output logic                  o_sign
);

   logic [EXP_WIDTH-1:0] w_exp;
   logic [MAN_WIDTH-1:0] w_man;
   logic                 w_exp_ones;
   logic                 w_exp_zero;
   logic                 w_man_zero;

   assign w_exp      = i_num[DATA_WIDTH-2 -: EXP_WIDTH];
   assign w_man      = i_num[MAN_WIDTH-1:0];
   assign w_exp_ones = &w_exp;
   assign w_exp_zero = ~|w_exp;
   assign w_man_zero = ~|w_man;
   assign o_sign     = i_num[DATA_WIDTH-1];

   always_comb begin
      o_class = ClsNormal;
      if (w_exp_ones) begin
         if (w_man_zero)              o_class = ClsInf;
         else if (w_man[MAN_WIDTH-1]) o_class = ClsQnan;
         else                         o_class = ClsSnan;
      end else if (w_exp_zero) begin
         if (w_man_zero) o_class = ClsZero;
         else begin
`ifdef FP_EXC_DAZ_EN
            o_class = ClsZero;
`else
            o_class = ClsSubnormal;
`endif
         end
      end
   end

endmodule

// File: rtl/fp_exception_pipe.sv
// Two-stage IEEE-754 special-case resolver: classify, then resolve NaN/Inf/zero results
// and flags. Build option FP_EXC_DAZ_EN (in fp_classify) enables denormals-are-zero.
module fp_exception_pipe
   import fp_exc_pkg::*;
#(
   parameter int EXP_WIDTH = 8,
   parameter int MAN_WIDTH = 23,
   parameter int OP_WIDTH  = 2,
   localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] float_num1,
   input  logic [DATA_WIDTH-1:0] float_num2,
   input  logic [OP_WIDTH-1:0]   opcode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sel,
   output logic [DATA_WIDTH-1:0] exception_out,
   output logic [1:0]            exc_flags,
   output logic [1:0]            sticky_flags,
   input  logic                  flags_clear
);

   localparam logic [MAX_DATA_W-1:0] L_QNAN_W = canon_qnan(EXP_WIDTH, MAN_WIDTH);
   localparam logic [DATA_WIDTH-1:0] L_QNAN   = L_QNAN_W[DATA_WIDTH-1:0];
   localparam logic [OP_WIDTH-1:0]   L_OP_ADD = OP_WIDTH'(OP_ADD);
   localparam logic [OP_WIDTH-1:0]   L_OP_SUB = OP_WIDTH'(OP_SUB);
   localparam logic [OP_WIDTH-1:0]   L_OP_MUL = OP_WIDTH'(OP_MUL);
   localparam logic [OP_WIDTH-1:0]   L_OP_DIV = OP_WIDTH'(OP_DIV);

   function automatic logic [DATA_WIDTH-1:0] f_inf(input logic s);
      return {s, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
   endfunction

   function automatic logic [DATA_WIDTH-1:0] f_zero(input logic s);
      return {s, {(DATA_WIDTH-1){1'b0}}};
   endfunction

   fp_class_e w_cls1, w_cls2;
   logic      w_sign1, w_sign2;

   fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_cls1 (
      .i_num   (float_num1),
      .o_class (w_cls1),
      .o_sign  (w_sign1)
   );

   fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_cls2 (
      .i_num   (float_num2),
      .o_class (w_cls2),
      .o_sign  (w_sign2)
   );

   logic                  r_s1_valid;
   fp_class_e             r_s1_cls1, r_s1_cls2;
   logic                  r_s1_sign1, r_s1_sign2;
   logic [OP_WIDTH-1:0]   r_s1_op;
   logic                  r_out_valid;
   logic                  r_sel;
   logic [DATA_WIDTH-1:0] r_exc;
   logic [1:0]            r_flags;
   logic [1:0]            r_sticky;

   logic w_s2_load, w_in_xfer, w_out_xfer;
   assign w_s2_load  = !r_out_valid || out_ready;
   assign in_ready   = !r_s1_valid || w_s2_load;
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = r_out_valid && out_ready;

   logic w_inf1, w_inf2, w_zero1, w_zero2, w_nan1, w_nan2, w_snan_any;
   logic w_sign2_eff, w_sign_x;
   assign w_inf1      = (r_s1_cls1 == ClsInf);
   assign w_inf2      = (r_s1_cls2 == ClsInf);
   assign w_zero1     = (r_s1_cls1 == ClsZero);
   assign w_zero2     = (r_s1_cls2 == ClsZero);
   assign w_nan1      = (r_s1_cls1 == ClsQnan) || (r_s1_cls1 == ClsSnan);
   assign w_nan2      = (r_s1_cls2 == ClsQnan) || (r_s1_cls2 == ClsSnan);
   assign w_snan_any  = (r_s1_cls1 == ClsSnan) || (r_s1_cls2 == ClsSnan);
   assign w_sign2_eff = r_s1_sign2 ^ (r_s1_op == L_OP_SUB);
   assign w_sign_x    = r_s1_sign1 ^ r_s1_sign2;

   logic                  w_sel;
   logic [DATA_WIDTH-1:0] w_res;
   logic [1:0]            w_flags;  // {invalid, divzero}

   always_comb begin
      w_sel   = 1'b0;
      w_res   = '0;
      w_flags = 2'b00;
      if (w_nan1 || w_nan2) begin
         w_sel      = 1'b1;
         w_res      = L_QNAN;
         w_flags[1] = w_snan_any;
      end else begin
         case (r_s1_op)
            L_OP_ADD, L_OP_SUB: begin
               if (w_inf1 && w_inf2 && (r_s1_sign1 != w_sign2_eff)) begin
                  w_sel = 1'b1; w_res = L_QNAN; w_flags = 2'b10;
               end else if (w_inf1) begin
                  w_sel = 1'b1; w_res = f_inf(r_s1_sign1);
               end else if (w_inf2) begin
                  w_sel = 1'b1; w_res = f_inf(w_sign2_eff);
               end else if (w_zero1 && w_zero2) begin
                  w_sel = 1'b1; w_res = f_zero(r_s1_sign1 && w_sign2_eff);
               end
            end
            L_OP_MUL: begin
               if ((w_inf1 && w_zero2) || (w_zero1 && w_inf2)) begin
                  w_sel = 1'b1; w_res = L_QNAN; w_flags = 2'b10;
               end else if (w_inf1 || w_inf2) begin
                  w_sel = 1'b1; w_res = f_inf(w_sign_x);
               end else if (w_zero1 || w_zero2) begin
                  w_sel = 1'b1; w_res = f_zero(w_sign_x);
               end
            end
            L_OP_DIV: begin
               // inf/0 is checked before x/0 so only finite dividends raise divzero
               if ((w_zero1 && w_zero2) || (w_inf1 && w_inf2)) begin
                  w_sel = 1'b1; w_res = L_QNAN; w_flags = 2'b10;
               end else if (w_inf1) begin
                  w_sel = 1'b1; w_res = f_inf(w_sign_x);
               end else if (w_zero2) begin
                  w_sel = 1'b1; w_res = f_inf(w_sign_x); w_flags = 2'b01;
               end else if (w_zero1 || w_inf2) begin
                  w_sel = 1'b1; w_res = f_zero(w_sign_x);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_cls1   <= ClsZero;
         r_s1_cls2   <= ClsZero;
         r_s1_sign1  <= 1'b0;
         r_s1_sign2  <= 1'b0;
         r_s1_op     <= '0;
         r_out_valid <= 1'b0;
         r_sel       <= 1'b0;
         r_exc       <= '0;
         r_flags     <= 2'b00;
         r_sticky    <= 2'b00;
      end else begin
         if (in_ready) r_s1_valid <= in_valid;
         if (w_in_xfer) begin
            r_s1_cls1  <= w_cls1;
            r_s1_cls2  <= w_cls2;
            r_s1_sign1 <= w_sign1;
            r_s1_sign2 <= w_sign2;
            r_s1_op    <= opcode;
         end
         if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            r_sel       <= r_s1_valid && w_sel;
            r_exc       <= r_s1_valid ? w_res : '0;
            r_flags     <= r_s1_valid ? w_flags : 2'b00;
         end
         if (w_out_xfer)       r_sticky <= flags_clear ? r_flags : (r_sticky | r_flags);
         else if (flags_clear) r_sticky <= 2'b00;
      end
   end

   assign out_valid     = r_out_valid;
   assign sel           = r_sel;
   assign exception_out = r_exc;
   assign exc_flags     = r_flags;
   assign sticky_flags  = r_sticky;

endmodule

// File: tb/tb_fp_exception_pipe.sv
// Self-checking bench for fp_exception_pipe: directed special cases, backpressure,
// sticky-flag and reset checks, then randomized traffic against a reference model.
module tb_fp_exception_pipe;

   typedef struct packed {
      logic        sel;
      logic [31:0] val;
      logic [1:0]  flags;
   } exp_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, sel, flags_clear;
   logic [31:0] float_num1, float_num2, exception_out;
   logic [1:0]  opcode, exc_flags, sticky_flags;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q[$];
   logic [1:0] sticky_m = 2'b00;

   fp_exception_pipe dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .float_num1    (float_num1),
      .float_num2    (float_num2),
      .opcode        (opcode),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .sel           (sel),
      .exception_out (exception_out),
      .exc_flags     (exc_flags),
      .sticky_flags  (sticky_flags),
      .flags_clear   (flags_clear)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: special-case arithmetic straight from the IEEE rules.
   function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] op);
      exp_t r;
      bit nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b, sa, sb, sx;
      bit daz;
`ifdef FP_EXC_DAZ_EN
      daz = 1'b1;
`else
      daz = 1'b0;
`endif
      nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      snan_a = nan_a && !a[22];
      snan_b = nan_b && !b[22];
      inf_a  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      inf_b  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      zero_a = (a[30:23] == 0) && ((a[22:0] == 0) || daz);
      zero_b = (b[30:23] == 0) && ((b[22:0] == 0) || daz);
      sa = a[31];
      sb = b[31] ^ (op == 2'd1);
      sx = a[31] ^ b[31];
      r  = '0;
      if (nan_a || nan_b) r = '{1'b1, QNAN, {snan_a || snan_b, 1'b0}};
      else if (op <= 2'd1) begin
         if (inf_a && inf_b && sa != sb) r = '{1'b1, QNAN, 2'b10};
         else if (inf_a)                 r = '{1'b1, {sa, 31'h7F80_0000}, 2'b00};
         else if (inf_b)                 r = '{1'b1, {sb, 31'h7F80_0000}, 2'b00};
         else if (zero_a && zero_b)      r = '{1'b1, {sa & sb, 31'd0}, 2'b00};
      end else if (op == 2'd2) begin
         if ((inf_a && zero_b) || (zero_a && inf_b)) r = '{1'b1, QNAN, 2'b10};
         else if (inf_a || inf_b)   r = '{1'b1, {sx, 31'h7F80_0000}, 2'b00};
         else if (zero_a || zero_b) r = '{1'b1, {sx, 31'd0}, 2'b00};
      end else begin
         if ((zero_a && zero_b) || (inf_a && inf_b)) r = '{1'b1, QNAN, 2'b10};
         else if (inf_a)            r = '{1'b1, {sx, 31'h7F80_0000}, 2'b00};
         else if (zero_b)           r = '{1'b1, {sx, 31'h7F80_0000}, 2'b01};
         else if (zero_a || inf_b)  r = '{1'b1, {sx, 31'd0}, 2'b00};
      end
      return r;
   endfunction

   function automatic logic [31:0] gen_operand();
      logic [31:0] r;
      logic [7:0]  e;
      r = $urandom;
      e = 8'($urandom_range(1, 254));
      case ($urandom_range(0, 6))
         0:       return {r[31], 31'd0};
         1:       return {r[31], 8'hFF, 23'd0};
         2:       return {r[31], 8'hFF, 1'b1, r[21:0]};
         3:       return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
         4:       return {r[31], 8'h00, r[22:1], 1'b1};
         default: return {r[31], e, r[22:0]};
      endcase
   endfunction

   // One clock: score the pre-edge handshake, advance, then check sticky flags.
   task automatic cycle(output bit acc);
      bit   ov, xfer;
      exp_t e;
      #1;
      acc  = in_valid && in_ready && !rst;
      ov   = out_valid && !rst;
      xfer = 1'b0;
      if (ov) begin
         check("out_pending", 64'(q.size() != 0), 64'd1);
         if (q.size() != 0) begin
            e = q[0];
            check("out_sel", 64'(sel), 64'(e.sel));
            check("out_val", 64'(exception_out), 64'(e.val));
            check("out_flags", 64'(exc_flags), 64'(e.flags));
            if (out_ready) begin
               void'(q.pop_front());
               xfer     = 1'b1;
               sticky_m = flags_clear ? e.flags : (sticky_m | e.flags);
            end
         end
      end
      if (!xfer && flags_clear) sticky_m = 2'b00;
      if (rst) begin
         q.delete();
         sticky_m = 2'b00;
      end
      if (acc) q.push_back(ref_model(float_num1, float_num2, opcode));
      @(posedge clk);
      #1;
      check("sticky", 64'(sticky_flags), 64'(sticky_m));
      if (rst) begin
         check("rst_out_valid", 64'(out_valid), 64'd0);
         check("rst_in_ready", 64'(in_ready), 64'd1);
      end
   endtask

   task automatic do_reset();
      bit acc;
      rst = 1'b1; in_valid = 1'b0; flags_clear = 1'b0; out_ready = 1'b1;
      cycle(acc);
      rst = 1'b0;
   endtask

   task automatic put(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      bit acc;
      in_valid = 1'b1; float_num1 = a; float_num2 = b; opcode = op;
      cycle(acc);
      check("put_accept", 64'(acc), 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle();
      bit acc;
      in_valid = 1'b0;
      cycle(acc);
   endtask

   logic [31:0] va[4], vb[4];
   logic [1:0]  vo[4];

   initial begin
      bit acc;
      int idx;
      float_num1 = '0; float_num2 = '0; opcode = '0;
      do_reset();
      check("rst_sel", 64'(sel), 64'd0);
      check("rst_exc", 64'(exception_out), 64'd0);
      check("rst_flags", 64'(exc_flags), 64'd0);

      // inf + -inf: invalid, two-cycle latency
      put(32'h7F80_0000, 32'hFF80_0000, 2'd0);
      check("t1_lat1", 64'(out_valid), 64'd0);
      idle();
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_sel", 64'(sel), 64'd1);
      check("t1_val", 64'(exception_out), 64'h7FC0_0000);
      check("t1_flags", 64'(exc_flags), 64'd2);
      idle();

      // 1 / -0: divzero, -inf
      do_reset();
      put(32'h3F80_0000, 32'h8000_0000, 2'd3);
      idle();
      check("t2_val", 64'(exception_out), 64'hFF80_0000);
      check("t2_flags", 64'(exc_flags), 64'd1);
      idle();
      check("t2_sticky", 64'(sticky_flags), 64'd1);

      // sNaN * 1 and a plain add
      put(32'h7FA0_0000, 32'h3F80_0000, 2'd2);
      idle();
      check("t3_val", 64'(exception_out), 64'h7FC0_0000);
      check("t3_inv", 64'(exc_flags[1]), 64'd1);
      idle();
      put(32'h3F80_0000, 32'h4000_0000, 2'd0);
      idle();
      check("t3_add_sel", 64'(sel), 64'd0);
      check("t3_add_val", 64'(exception_out), 64'd0);
      idle();

      // Backpressure: out_ready low for 3 cycles, 4 back-to-back inputs
      do_reset();
      va = '{32'h7F80_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000};
      vb = '{32'hFF80_0000, 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000};
      vo = '{2'd0, 2'd3, 2'd2, 2'd0};
      idx = 0;
      for (int k = 0; k < 40 && (idx < 4 || q.size() != 0); k++) begin
         out_ready = (k >= 3);
         in_valid  = (idx < 4);
         if (idx < 4) begin
            float_num1 = va[idx]; float_num2 = vb[idx]; opcode = vo[idx];
         end
         cycle(acc);
         if (acc) idx++;
         if (k == 1) begin
            check("bp_acc_cnt", 64'(idx), 64'd2);
            check("bp_in_ready", 64'(in_ready), 64'd0);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("bp_all_in", 64'(idx), 64'd4);
      check("bp_drained", 64'(q.size()), 64'd0);

      // flags_clear coincident with a divzero transfer
      do_reset();
      put(32'h7F80_0000, 32'hFF80_0000, 2'd0);
      put(32'h3F80_0000, 32'h0000_0000, 2'd3);
      idle();
      check("fc_pre", 64'(sticky_flags), 64'd2);
      flags_clear = 1'b1;
      idle();
      flags_clear = 1'b0;
      check("fc_sticky", 64'(sticky_flags), 64'd1);

      // Reset mid-stream, with a transfer offered in the reset cycle
      put(32'h3F80_0000, 32'h0000_0000, 2'd3);
      put(32'h0000_0000, 32'h0000_0000, 2'd3);
      rst = 1'b1; in_valid = 1'b1;
      cycle(acc);
      rst = 1'b0; in_valid = 1'b0;
      check("rst_mid_valid", 64'(out_valid), 64'd0);
      idle();
      check("rst_flush", 64'(out_valid), 64'd0);

      // Subnormal dividend over zero
      put(32'h0000_0001, 32'h0000_0000, 2'd3);
      idle();
`ifdef FP_EXC_DAZ_EN
      check("sub_val", 64'(exception_out), 64'h7FC0_0000);
      check("sub_flags", 64'(exc_flags), 64'd2);
`else
      check("sub_val", 64'(exception_out), 64'h7F80_0000);
      check("sub_flags", 64'(exc_flags), 64'd1);
`endif
      idle();

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         flags_clear = ($urandom_range(0, 15) == 0);
         float_num1  = gen_operand();
         float_num2  = gen_operand();
         opcode      = 2'($urandom_range(0, 3));
         cycle(acc);
      end
      in_valid = 1'b0; out_ready = 1'b1; flags_clear = 1'b0;
      for (int k = 0; k < 10; k++) idle();
      check("rand_drained", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
